// File: rtl/lcd_pixel_feeder.sv
// Byte-stream to RGB565 pixel feeder for the LCD top: pairs bytes big-endian,
// buffers words in a block-RAM FIFO and serves one pixel per data_req.
module lcd_pixel_feeder #(
  parameter int          ADDR_W     = 10,
  parameter logic [15:0] FILL_COLOR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              frame_sync,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic              data_req,
  output logic [15:0]       pixel_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic              frame_done,
  output logic [15:0]       underflow_cnt
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {BYTE_HI, BYTE_LO} byte_state_e;

  byte_state_e       state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              rx_ready_q, rx_ready_d;
  logic              fill_sel_q, fill_sel_d;
  logic [15:0]       uf_q, uf_d;
  logic [21:0]       pix_cnt_q, pix_cnt_d;
  logic              frame_done_q, frame_done_d;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       ram_rd_q;

  logic              accept, wr_en, pop, underrun, frame_end;
  logic [21:0]       frame_total;

  assign frame_total = {11'd0, h_disp} * {11'd0, v_disp};

  always_comb begin
    accept    = rx_valid & rx_ready_q & ~frame_sync;
    wr_en     = accept & (state_q == BYTE_LO);
    pop       = data_req & ~frame_sync & (level_q != '0);
    underrun  = data_req & ~frame_sync & (level_q == '0);
    // A zero-sized frame must never match, even after the counter wraps.
    frame_end = data_req & ~frame_sync & (frame_total != 22'd0) &
                (pix_cnt_q == frame_total - 22'd1);

    state_d      = state_q;
    hi_d         = hi_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    fill_sel_d   = fill_sel_q;
    uf_d         = uf_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = frame_end;

    if (frame_sync) begin
      state_d    = BYTE_HI;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      pix_cnt_d  = '0;
      fill_sel_d = 1'b1;
    end else begin
      if (accept) begin
        if (state_q == BYTE_HI) begin
          hi_d    = rx_data;
          state_d = BYTE_LO;
        end else begin
          state_d = BYTE_HI;
        end
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (pop)      fill_sel_d = 1'b0;
      if (underrun) begin
        fill_sel_d = 1'b1;
        if (uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
      end
      if (data_req) pix_cnt_d = frame_end ? 22'd0 : pix_cnt_q + 22'd1;
    end

    rx_ready_d = (level_d < FULL_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BYTE_HI;
      hi_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rx_ready_q   <= 1'b0;
      fill_sel_q   <= 1'b1;
      uf_q         <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rx_ready_q   <= rx_ready_d;
      fill_sel_q   <= fill_sel_d;
      uf_q         <= uf_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // RAM and its read register stay reset-free so they map onto block RAM;
  // fill_sel_q masks the read register whenever it holds stale data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {hi_q, rx_data};
    if (pop)   ram_rd_q      <= mem[rd_ptr_q];
  end

  assign pixel_data    = fill_sel_q ? FILL_COLOR : ram_rd_q;
  assign rx_ready      = rx_ready_q;
  assign fifo_level    = level_q;
  assign frame_done    = frame_done_q;
  assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Scoreboard bench for lcd_pixel_feeder: stimulus queues expected pixels,
// a monitor compares pixel_data on the cycle after each request.
module tb_lcd_pixel_feeder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_sync;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic        data_req;
  logic [15:0] pixel_data;
  logic [10:0] fifo_level;
  logic        frame_done;
  logic [15:0] underflow_cnt;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  lcd_pixel_feeder #(.ADDR_W(10), .FILL_COLOR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_sync(frame_sync), .h_disp(h_disp),
    .v_disp(v_disp), .data_req(data_req), .pixel_data(pixel_data),
    .fifo_level(fifo_level), .frame_done(frame_done),
    .underflow_cnt(underflow_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: a request (or frame_sync) seen at a posedge produces a pixel
  // that is compared at the following negedge.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      if (rst_n && (data_req || frame_sync)) begin
        @(negedge clk);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pixel: got %04h, required no output (queue empty)", pixel_data);
        end else begin
          e = exp_q.pop_front();
          if (pixel_data !== e) begin
            fails++;
            $display("FAIL pixel: got %04h, required %04h", pixel_data, e);
          end else begin
            $display("[TB] pixel %04h", pixel_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("[TB] %s = %0h", name, act);
    end
  endtask

  // Leaves rx_valid high; the caller must drop it or change data at once.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (!rx_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_wait: got 0, required 1 within 50 cycles");
    end
    tick();
  endtask

  task automatic req(input logic [15:0] e);
    exp_q.push_back(e);
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
  endtask

  task automatic fsync();
    exp_q.push_back(16'h0000);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; rx_data = '0; rx_valid = 1'b0; frame_sync = 1'b0;
    h_disp = '0; v_disp = '0; data_req = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    check("reset_pixel", 32'(pixel_data), 32'h0000);
    check("reset_level", 32'(fifo_level), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    check("reset_underflow", 32'(underflow_cnt), 0);
    check("reset_rx_ready", 32'(rx_ready), 0);
    rst_n = 1'b1;
    tick();
    check("rx_ready_after_release", 32'(rx_ready), 1);

    // Basic packing, big-endian
    send_byte(8'hF8); send_byte(8'h00); send_byte(8'h07); send_byte(8'hE0);
    rx_valid = 1'b0;
    check("level_two_words", 32'(fifo_level), 2);
    req(16'hF800);
    req(16'h07E0);
    check("level_drained", 32'(fifo_level), 0);

    // Underflow on empty FIFO
    req(16'h0000); req(16'h0000); req(16'h0000);
    check("underflow_three", 32'(underflow_cnt), 3);
    send_byte(8'hF8);
    rx_data = 8'h11;
    exp_q.push_back(16'h0000);
    data_req = 1'b1;
    tick();
    data_req = 1'b0; rx_valid = 1'b0;
    check("underflow_write_same_cycle", 32'(underflow_cnt), 4);
    check("level_after_coincident_write", 32'(fifo_level), 1);
    req(16'hF811);
    check("frame_done_zero_disp", 32'(frame_done), 0);

    // Fill to full
    for (int i = 0; i < 2048; i++) send_byte(8'(i));
    rx_valid = 1'b0;
    check("level_full", 32'(fifo_level), 1024);
    check("rx_ready_full", 32'(rx_ready), 0);
    rx_data = 8'h55; rx_valid = 1'b1;
    tick();
    check("level_full_hold", 32'(fifo_level), 1024);
    exp_q.push_back(16'h0001);
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    check("level_after_pop", 32'(fifo_level), 1023);
    check("rx_ready_after_pop", 32'(rx_ready), 1);
    tick();
    rx_data = 8'h66;
    tick();
    rx_valid = 1'b0;
    check("level_refilled", 32'(fifo_level), 1024);
    check("rx_ready_refull", 32'(rx_ready), 0);
    fsync();
    check("level_after_flush", 32'(fifo_level), 0);

    // Frame position with 4x2 display
    h_disp = 11'd4; v_disp = 11'd2;
    fsync();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(16'h0000);
      data_req = 1'b1;
      tick();
      check($sformatf("frame_done_req%0d", i + 1), 32'(frame_done),
            (i == 7 || i == 15) ? 32'd1 : 32'd0);
    end
    data_req = 1'b0;
    tick();
    check("frame_done_after", 32'(frame_done), 0);
    check("underflow_after_frames", 32'(underflow_cnt), 20);

    // frame_sync drops a half pair and suppresses a coincident request
    send_byte(8'hC0); send_byte(8'hDE); send_byte(8'hAB);
    rx_valid = 1'b0;
    exp_q.push_back(16'h0000);
    frame_sync = 1'b1; data_req = 1'b1;
    tick();
    frame_sync = 1'b0; data_req = 1'b0;
    check("level_after_sync", 32'(fifo_level), 0);
    check("underflow_sync_no_count", 32'(underflow_cnt), 20);
    send_byte(8'h12); send_byte(8'h34);
    rx_valid = 1'b0;
    check("level_after_resync", 32'(fifo_level), 1);
    req(16'h1234);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) send_byte(8'h30 + 8'(i));
    send_byte(8'h77);
    rx_valid = 1'b0;
    check("level_five", 32'(fifo_level), 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_pixel", 32'(pixel_data), 32'h0000);
    check("async_level", 32'(fifo_level), 0);
    check("async_rx_ready", 32'(rx_ready), 0);
    check("async_underflow", 32'(underflow_cnt), 0);
    check("async_frame_done", 32'(frame_done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'hAB); send_byte(8'hCD);
    rx_valid = 1'b0;
    check("level_after_reset_pair", 32'(fifo_level), 1);
    req(16'hABCD);
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
